// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for fetch_queue: push side, pop side, flush and occupancy.
interface fetch_queue_if #(
    parameter int unsigned AW = 2
);
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic [AW:0]   count;

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO of {pc, instr} pairs between fetch and decode, with flush.
// Optional FETCH_QUEUE_BYPASS_EN adds a zero-latency in->out path when the queue is empty.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.slave  bus
);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = 64;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    logic          full;
    logic          empty;
    logic          byp;
    logic          push;
    logic          pop;
    logic          store;
    logic          take;
    logic [DW-1:0] head;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

    // Empty-queue bypass: fetch data is presented straight to decode.
    always_comb begin
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = rst_n & empty & ~bus.flush & bus.in_valid;
`endif
    end

    // Handshake and head presentation; flush masks both sides.
    always_comb begin
        bus.in_ready  = rst_n & ~bus.flush & ~full;
        bus.out_valid = (~bus.flush & ~empty) | byp;
        head          = byp ? {bus.in_pc, bus.in_instr} : mem[rd_ptr];
        bus.out_pc    = bus.out_valid ? head[DW-1:32] : 32'h0;
        bus.out_instr = bus.out_valid ? head[31:0]    : 32'h0;
        bus.count     = cnt;
    end

    // A bypassed entry consumed in the same cycle is neither stored nor popped from mem.
    always_comb begin
        push  = bus.in_valid & bus.in_ready;
        pop   = bus.out_valid & bus.out_ready;
        store = push & ~(byp & bus.out_ready);
        take  = pop & ~byp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + AW'(1);
            if (take)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(store) - CW'(take);
        end
    end

    // Payload storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= {bus.in_pc, bus.in_instr};
    end
endmodule
